// File: rtl/pilot_subcarrier_map.sv
// 802.11 OFDM subcarrier mapper: 48 data samples in, 64 frequency-ordered samples out
// per symbol, with four LFSR-polarised BPSK pilots and zeroed null/DC bins.
module pilot_subcarrier_map #(
   parameter logic [15:0] PILOT_AMP = 16'h13C0
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] DAT_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I
);

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic [1:0] {SC_NULL, SC_PILOT, SC_DATA} sc_kind_t;

   localparam logic [6:0]  LFSR_SEED = 7'h7F;
   localparam logic [15:0] PILOT_NEG = ~PILOT_AMP + 16'd1;

   state_t      state, state_nxt;
   logic [5:0]  pos, pos_nxt;
   logic [6:0]  lfsr, lfsr_nxt;
   logic [31:0] dat_q, dat_nxt;
   logic        stb_q, stb_nxt;
   logic        cyc_q, cyc_nxt;
   logic        last_q, last_nxt;

   sc_kind_t    kind;
   logic        in_valid;
   logic        out_halt;
   logic        load;
   logic        take;
   logic        pilot_bit;
   logic        pilot_neg;
   logic [15:0] pilot_re;

   // Position pos maps to subcarrier k = pos - 32.
   function automatic sc_kind_t classify(input logic [5:0] p);
      if (p <= 6'd5 || p == 6'd32 || p >= 6'd59)
         return SC_NULL;
      else if (p == 6'd11 || p == 6'd25 || p == 6'd39 || p == 6'd53)
         return SC_PILOT;
      else
         return SC_DATA;
   endfunction

   always_comb begin
      kind      = classify(pos);
      in_valid  = CYC_I & STB_I & WE_I;
      out_halt  = stb_q & ~ACK_I;
      pilot_bit = lfsr[6] ^ lfsr[3];
      pilot_neg = pilot_bit ^ (pos == 6'd53);
      pilot_re  = pilot_neg ? PILOT_NEG : PILOT_AMP;
      take      = (state == RUN) & (kind == SC_DATA) & in_valid & ~out_halt;
      if (state == IDLE)
         load = in_valid & ~out_halt;
      else
         load = ~out_halt & ((kind != SC_DATA) | in_valid);
   end

   // NOTE: every next-state signal takes its current value first, so no path through this
   // block leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      lfsr_nxt  = lfsr;
      dat_nxt   = dat_q;
      stb_nxt   = stb_q;
      cyc_nxt   = cyc_q;
      last_nxt  = last_q;

      if (load) begin
         stb_nxt   = 1'b1;
         cyc_nxt   = 1'b1;
         last_nxt  = 1'b0;
         state_nxt = RUN;
         pos_nxt   = pos + 6'd1;
         unique case (kind)
            SC_DATA:  dat_nxt = DAT_I;
            SC_PILOT: dat_nxt = {16'h0000, pilot_re};
            default:  dat_nxt = 32'h0000_0000;
         endcase
         if (pos == 6'd63) begin
            if (CYC_I) begin
               lfsr_nxt = {lfsr[5:0], pilot_bit};
            end else begin
               // Frame over: reseed so the next frame restarts the pilot sequence at p_0.
               state_nxt = IDLE;
               lfsr_nxt  = LFSR_SEED;
               last_nxt  = 1'b1;
            end
         end
      end else if (stb_q & ACK_I) begin
         stb_nxt = 1'b0;
         if (last_q) begin
            cyc_nxt  = 1'b0;
            last_nxt = 1'b0;
         end
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state  <= IDLE;
         pos    <= 6'd0;
         lfsr   <= LFSR_SEED;
         dat_q  <= 32'h0000_0000;
         stb_q  <= 1'b0;
         cyc_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         pos    <= pos_nxt;
         lfsr   <= lfsr_nxt;
         dat_q  <= dat_nxt;
         stb_q  <= stb_nxt;
         cyc_q  <= cyc_nxt;
         last_q <= last_nxt;
      end
   end

   assign ACK_O = take;
   assign DAT_O = dat_q;
   assign STB_O = stb_q;
   assign WE_O  = stb_q;
   assign CYC_O = cyc_q;

endmodule

// File: tb/tb_pilot_subcarrier_map.sv
// Bench for pilot_subcarrier_map: random frames compared against a subcarrier-rule model
// built from k-index rules and a recurrence-generated pilot polarity sequence.
module tb_pilot_subcarrier_map;

   localparam logic [15:0] AMP     = 16'h13C0;
   localparam logic [15:0] NEG_AMP = 16'hEC40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] dat_i;
   logic        cyc_i, stb_i, we_i, ack_o;
   logic [31:0] dat_o;
   logic        cyc_o, stb_o, we_o, ack_i;

   always #5 clk = ~clk;

   pilot_subcarrier_map dut (
      .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
      .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] src_q[$];
   logic [31:0] out_q[$];
   logic [31:0] exp_q[$];
   int          src_idx, acks, stb_cycles, cyc_on, bad_acks, hold_errs, stall_cycles;
   int          stall_idx, stall_cnt;
   bit          gap_mode, stall_mode, rand_ack, gap_phase, hold_prev;
   logic [31:0] held;
   bit          pn_seq[0:299];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] got(input int i);
      if (i < out_q.size()) return out_q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic drive();
      int lim;
      bit have;
      have  = (src_idx < src_q.size());
      cyc_i = have;
      stb_i = have;
      we_i  = 1'b1;
      dat_i = 32'h0;
      if (have) dat_i = src_q[src_idx];
      gap_phase = ~gap_phase;
      if (gap_mode && have && !gap_phase) begin
         if ($urandom_range(0, 1) == 0) stb_i = 1'b0;
         else                           we_i  = 1'b0;
      end
      ack_i = 1'b1;
      if (stall_mode) begin
         if (out_q.size() != stall_idx) begin
            stall_idx = out_q.size();
            stall_cnt = 0;
         end
         lim = (stall_idx % 64 == 20) ? 3 : (stall_idx % 64 == 25) ? 2 : 0;
         if (stb_o && stall_cnt < lim) begin
            ack_i = 1'b0;
            stall_cnt++;
            stall_cycles++;
         end
      end else if (rand_ack) begin
         ack_i = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic sample();
      if (hold_prev && (dat_o !== held || stb_o !== 1'b1)) hold_errs++;
      if (stb_o && !ack_i && ack_o) hold_errs++;
      hold_prev = stb_o && !ack_i;
      held      = dat_o;
      if (ack_o && !(cyc_i && stb_i && we_i)) bad_acks++;
      if (ack_o) begin
         acks++;
         src_idx++;
      end
      if (stb_o) stb_cycles++;
      if (stb_o && ack_i) begin
         out_q.push_back(dat_o);
         if (cyc_o) cyc_on++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_frame(input int nsym, input bit directed, input bit gaps,
                            input bit stalls, input bit rnd_ack, input int stop_at);
      int total, d, cycles, k, goal;
      bit neg;
      total = nsym * 64;
      goal  = (stop_at >= 0) ? stop_at : total;
      src_q.delete(); out_q.delete(); exp_q.delete();
      src_idx = 0; acks = 0; stb_cycles = 0; cyc_on = 0; bad_acks = 0; hold_errs = 0;
      stall_cycles = 0; hold_prev = 0; stall_idx = -1; stall_cnt = 0;
      gap_mode = gaps; stall_mode = stalls; rand_ack = rnd_ack;
      for (int i = 0; i < nsym * 48; i++)
         src_q.push_back(directed ? {16'h0000, 16'(i + 1)} : 32'($urandom));
      d = 0;
      for (int s = 0; s < nsym; s++) begin
         for (int p = 0; p < 64; p++) begin
            k = p - 32;
            if (k < -26 || k > 26 || k == 0) begin
               exp_q.push_back(32'h0);
            end else if (k == -21 || k == -7 || k == 7 || k == 21) begin
               neg = pn_seq[s + 7] ^ (k == 21);
               exp_q.push_back({16'h0000, neg ? NEG_AMP : AMP});
            end else begin
               exp_q.push_back(src_q[d]);
               d++;
            end
         end
      end
      drive();
      cycles = 0;
      while (out_q.size() < goal && cycles < 5 * total + 200) begin
         step();
         cycles++;
      end
      if (stop_at >= 0) begin
         check("partial_progress", 32'(out_q.size()), 32'(stop_at));
         return;
      end
      check("sample_count", 32'(out_q.size()), 32'(total));
      @(negedge clk);
      check("cyc_o_after_frame", {31'b0, cyc_o}, 32'd0);
      check("stb_o_after_frame", {31'b0, stb_o}, 32'd0);
      check("ack_count", 32'(acks), 32'(nsym * 48));
      check("cyc_o_during_xfer", 32'(cyc_on), 32'(total));
      check("ack_without_valid", 32'(bad_acks), 32'd0);
      check("halt_hold_violations", 32'(hold_errs), 32'd0);
      for (int i = 0; i < total; i++)
         check($sformatf("sym%0d_pos%0d", i / 64, i % 64), got(i), exp_q[i]);
   endtask

   initial begin
      logic [15:0] p11 [5];
      p11 = '{AMP, AMP, AMP, AMP, NEG_AMP};

      // Pilot polarity bits: seven leading ones, then b[n] = b[n-7] ^ b[n-4].
      for (int i = 0; i < 7; i++) pn_seq[i] = 1'b1;
      for (int i = 7; i < 300; i++) pn_seq[i] = pn_seq[i - 7] ^ pn_seq[i - 4];

      rst_n = 1'b0; dat_i = '0; cyc_i = 0; stb_i = 0; we_i = 0; ack_i = 1'b1;
      gap_phase = 0; hold_prev = 0; src_idx = 0;
      #1;
      check("reset_dat_o", dat_o, 32'h0);
      check("reset_stb_o", {31'b0, stb_o}, 32'd0);
      check("reset_cyc_o", {31'b0, cyc_o}, 32'd0);
      check("reset_we_o",  {31'b0, we_o},  32'd0);
      check("reset_ack_o", {31'b0, ack_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single directed symbol, full-rate downstream.
      run_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      check("s1_pos6",  got(6),  32'h0000_0001);
      check("s1_pos11", got(11), 32'h0000_13C0);
      check("s1_pos32", got(32), 32'h0000_0000);
      check("s1_pos53", got(53), 32'h0000_EC40);
      check("s1_pos58", got(58), 32'h0000_0030);
      check("s1_stb_cycles", 32'(stb_cycles), 32'd64);

      // Five back-to-back symbols: pilot polarity progression and continuous CYC_O.
      run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      for (int s = 0; s < 5; s++) begin
         check($sformatf("b2b_pilot11_sym%0d", s), got(s * 64 + 11), {16'h0000, p11[s]});
         check($sformatf("b2b_pilot53_sym%0d", s), got(s * 64 + 53),
               {16'h0000, (p11[s] == AMP) ? NEG_AMP : AMP});
      end
      check("b2b_stb_cycles", 32'(stb_cycles), 32'd320);

      // Downstream stalls at pos 20 (3 cycles) and pos 25 (2 cycles).
      run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      check("stall_cycles", 32'(stall_cycles), 32'd10);

      // Upstream gaps with the directed data; first pilot shows a reseeded LFSR.
      run_frame(1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
      check("gap_pos11_reseed", got(11), 32'h0000_13C0);

      // Reset in the middle of a symbol.
      run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 30);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_dat_o", dat_o, 32'h0);
      check("midrst_stb_o", {31'b0, stb_o}, 32'd0);
      check("midrst_cyc_o", {31'b0, cyc_o}, 32'd0);
      check("midrst_ack_o", {31'b0, ack_o}, 32'd0);
      src_q.delete();
      src_idx = 0;
      @(negedge clk);
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check("post_rst_pos11", got(11), 32'h0000_13C0);

      // Long frame past the LFSR period, random gaps and random downstream backpressure.
      run_frame(128, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      check("period_p127_pos11", got(127 * 64 + 11), 32'h0000_13C0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pilot_subcarrier_map.md
# pilot_subcarrier_map

Streaming OFDM subcarrier mapper placed directly downstream of the QAM mapper in the 802.11 transmit chain. It consumes 48 complex data samples per OFDM symbol and emits 64 frequency-domain samples per symbol toward the IFFT, inserting four BPSK pilots with per-symbol polarity and zero-filling the null and DC subcarriers. Both sides use the codebase's Wishbone-style streaming handshake; there is no symbol buffer.

## Interface
- PILOT_AMP, 16'h13C0, unit pilot amplitude (Q1.15), equal to the ±1 constellation level of the 64-QAM mapper.
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- DAT_I  in  32  input sample {Im[31:16], Re[15:0]}, signed Q1.15.
- CYC_I  in  1  frame active, held high by upstream for the whole frame.
- STB_I  in  1  input sample valid.
- WE_I  in  1  write qualifier; input is valid only when CYC_I & STB_I & WE_I.
- ACK_O  out  1  input sample accepted this cycle.
- DAT_O  out  32  output sample {Im, Re}.
- CYC_O  out  1  output frame active.
- STB_O  out  1  output sample valid.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream accepts DAT_O.

## Operation
- Position counter pos runs from 0 to 63. Subcarrier k = pos - 32, so outputs are in natural frequency order, -32 to +31. FFT shifting is not done here.
- Nulls (DAT_O = 0): pos 0-5, pos 32 (DC), pos 59-63.
- Pilots: k = -21, -7, +7 (pos 11, 25, 39) carry Re = p_n·PILOT_AMP. k = +21 (pos 53) carries Re = -p_n·PILOT_AMP. Im = 0 for all pilots. -PILOT_AMP is the two's complement (16'hEC40 at the default).
- Data: the remaining 48 positions take input samples in arrival order d0..d47, mapped to k = -26..+26 skipping pilots and DC. d0 goes to pos 6, d5 to pos 12, d23 to pos 31, d24 to pos 33, d47 to pos 58.
- Pilot polarity p_n comes from a 7-bit LFSR, x^7+x^4+1, seeded 7'b1111111. The output bit b gives p = +1 when b = 0 and -1 when b = 1. The sequence starts +1,+1,+1,+1,-1,-1,-1,+1.
  - The LFSR advances once per symbol, after pos 63 is accepted downstream.
  - The LFSR is reseeded on entry to IDLE.
  - The period is 127 symbols; p_127 = p_0.
- State machine, two states:
  - IDLE: pos = 0. Moves to RUN when CYC_I & STB_I & WE_I.
  - RUN: emits positions in order.
    - At a data position, it waits for a valid input and accepts it.
    - At a null or pilot position, it generates the sample internally without consuming input, regardless of CYC_I or STB_I.
    - After pos 63 is accepted: stays in RUN with pos = 0 if CYC_I is high, otherwise goes to IDLE.
- A symbol, once started, always completes all 64 outputs. The trailing nulls are emitted even if CYC_I falls. If CYC_I falls mid-symbol, the symbol still finishes; missing data positions wait for input.
- ACK_O = CYC_I & STB_I & WE_I & (state == RUN or the IDLE→RUN start) & (current pos is a data position) & ~out_halt, where out_halt = STB_O & ~ACK_I.

## Timing
- Reset values: STB_O = 0, CYC_O = 0, DAT_O = 0, pos = 0, state = IDLE, LFSR = 7'h7F.
- The output register loads whenever ~out_halt and a sample is available: either an internally generated position, or a data position with an accepted input.
- Latency: accepted input to STB_O is 1 cycle. Throughput is 1 sample per cycle. A symbol takes at least 64 cycles and consumes 48 inputs.
- While out_halt is high: DAT_O, pos and ACK_O are frozen, with ACK_O = 0.
- STB_O drops the cycle after the last sample is accepted if no new sample is produced.
- CYC_O rises with the first STB_O of a frame. It falls the cycle after pos 63 of the final symbol is accepted.
- Simultaneous ACK_I and a new load: the output register reloads in the same cycle, with no bubble.
- Asserting reset at any time returns to the reset state immediately. A partial symbol is discarded.

## Test plan
- Single symbol, d_i = {16'h0, i+1}, ACK_I = 1.
  - Exactly 64 outputs, 48 ACK_O pulses.
  - pos 6 = 32'h00000001; pos 11 = 32'h000013C0; pos 32 = 0; pos 53 = 32'h0000EC40; pos 58 = 32'h00000030.
- Five back-to-back symbols:
  - The pilot at pos 11 reads 13C0, 13C0, 13C0, 13C0, EC40.
  - The pilot at pos 53 is always the negation.
  - CYC_O stays high for 320 samples.
- Downstream stall: ACK_I low for 3 cycles at pos 20 and for 2 cycles at pos 25 (pilot).
  - DAT_O and STB_O are held, ACK_O = 0.
  - No sample is lost or duplicated.
- Upstream gaps: STB_I toggles every cycle.
  - Internal positions (pos 0-5, 11) proceed without input.
  - Data positions wait; the output sequence is identical to the gap-free run.
- CYC_I drops after d47 of symbol 1.
  - pos 59-63 nulls are still emitted, then the block goes to IDLE.
  - In the next frame the first pilot is 13C0 (LFSR reseeded).
- RST_I low mid-symbol at pos 30.
  - Outputs go to 0 immediately.
  - The next frame starts at pos 0 with p_0 = +1.
